rtc_count_latch: RTL
====================

# rtc_count_latch

Stopwatch count core driven by the trigger-detection control outputs (`countinit`, `countenb`, `latchcount`). It holds the 24-bit elapsed-time counter behind a prescaler and captures the count on every `latchcount` transition. It also serialises each captured value as a 3-byte, MSB-first valid/ready stream toward the display/UART path.

## Interface
Parameters:
- `COUNT_WIDTH`, 24, counter width; must be a multiple of 8.
- `PRESCALE`, 1, number of `i_sclk` cycles per count tick; ≥1.

Ports:
- `i_sclk`  in  1  system clock; all logic is on its rising edge.
- `i_reset_n`  in  1  reset, asynchronous and active-low.
- `i_countinit`  in  1  synchronous clear of counter, prescaler and overflow.
- `i_countenb`  in  1  count enable (level).
- `i_latchcount`  in  1  latch request; every transition (either edge) is one event.
- `i_rd_ready`  in  1  downstream accepts the byte this cycle.
- `o_count`  out  COUNT_WIDTH  live counter value.
- `o_latched`  out  COUNT_WIDTH  most recently captured count.
- `o_overflow`  out  1  sticky; set on counter wrap.
- `o_rd_valid`  out  1  `o_rd_data` is valid.
- `o_rd_data`  out  8  readout byte.
- `o_rd_last`  out  1  final byte of the frame (LSB byte).

## Operation
- Reset values: `o_count`, `o_latched` = 0; `o_overflow`, `o_rd_valid`, `o_rd_last` = 0; `o_rd_data` = 0. Prescaler = 0, latch-sample register `lc_q` = 0, pending = 0, FSM in `RD_IDLE`.
- Prescaler: while `i_countenb`=1, it counts 0..PRESCALE-1. A tick occurs in the cycle where prescaler = PRESCALE-1, and the prescaler then returns to 0. While `i_countenb`=0 the prescaler holds its value.
- Counter: increments by 1 on each tick. At all-ones it wraps to 0 and sets `o_overflow`. `o_overflow` stays set until `i_countinit`.
- `i_countinit`=1 takes priority over enable. It clears the counter, prescaler and `o_overflow` at the next edge. It does not affect `o_latched`, the readout or `lc_q`.
- Latch event: `i_latchcount != lc_q`. On that edge, `lc_q <= i_latchcount` and `o_latched <=` the pre-update `o_count`. The captured value is the pre-clear value if `i_countinit` is also high, and the pre-increment value if a tick is also occurring.
- Readout FSM (`RD_IDLE`, `RD_SEND`):
  - `RD_IDLE` + latch event → `RD_SEND`. The frame shift register loads the same value written to `o_latched`, and the byte index is set to COUNT_WIDTH/8-1.
  - `RD_SEND`: `o_rd_valid`=1 and `o_rd_data` = frame byte at the current index, MSB byte first. `o_rd_last`=1 when index = 0.
  - Transfer occurs when `o_rd_valid & i_rd_ready`; the index then decrements.
  - Transfer of the last byte: if pending=0, go to `RD_IDLE`. If pending=1, reload the frame from `o_latched`, clear pending, and stay in `RD_SEND` with no idle gap.
  - Latch event while in `RD_SEND`: `o_latched` updates immediately and pending is set. The frame in flight is not modified. Multiple events during one frame collapse into one pending frame carrying the newest value.
  - If a latch event coincides with the last-byte transfer, the new value is the one loaded; pending stays 0.
- `o_rd_data` and `o_rd_last` hold stable while `o_rd_valid`=1 and `i_rd_ready`=0. `o_rd_data` = 0 in `RD_IDLE`.
- Reset asserted mid-frame: the frame is aborted immediately and all outputs return to their reset values.

## Timing
- All outputs are registered.
- Count latency: a tick edge updates `o_count` at that edge.
- With PRESCALE=1 and `i_countenb` held high, `o_count` increments every cycle.
- Latch to readout: `o_latched` and `o_rd_valid` are visible after the same edge that samples the transition.
- Full frame takes 3 cycles minimum with `i_rd_ready` held high.
- Back-to-back frames start on the cycle after the last transfer.

## Structure
- `rtc_pkg`: `COUNT_WIDTH_DEF` = 24, `RD_BYTES` = COUNT_WIDTH/8 (function or localparam), `typedef enum logic {RD_IDLE, RD_SEND} rd_state_t`.
- Sub-module `rtc_prescaler`: parameter `PRESCALE`; inputs clk, reset, clear, enable; output `o_tick`. Counter, latch/edge logic and readout FSM stay in the top module.

## Test plan
- Reset then count: PRESCALE=1, `i_countinit` pulse, `i_countenb`=1 for 10 cycles → `o_count`=10, `o_overflow`=0.
- Prescale: PRESCALE=4, enable for 12 cycles → `o_count`=3; drop enable for 5 cycles and re-enable for 4 → `o_count`=4 (prescaler phase held).
- Wrap: preload via counting with COUNT_WIDTH=8 to 0xFF, one more tick → `o_count`=0, `o_overflow`=1; `i_countinit` → `o_overflow`=0.
- Latch and readout: count to 0x12_34_56, toggle `i_latchcount`, `i_rd_ready`=1 → `o_latched`=0x123456; bytes 0x12, 0x34, 0x56 on consecutive cycles with `o_rd_last` only on 0x56.
- Backpressure and pending: `i_rd_ready`=0 holding byte 0x12 stable for 5 cycles; two more latch toggles at counts 0x000100 and 0x000105 → current frame completes unchanged, then exactly one further frame 0x00, 0x01, 0x05.
- Reset mid-frame: assert `i_reset_n`=0 after the first byte → `o_rd_valid`=0 and all outputs 0 immediately; after release, no residual frame is emitted.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and sizing helpers for the stopwatch count/latch core.
package rtc_pkg;

  localparam int COUNT_WIDTH_DEF = 24;

  typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

  function automatic int rd_bytes(input int count_width);
    return count_width / 8;
  endfunction

  // A single-byte frame still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtc_count_latch_if.sv
// Byte readout stream (valid/ready) from the count core toward display/UART.
interface rtc_count_latch_if;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_ready;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/rtc_prescaler.sv
// Divides the system clock into count ticks; phase is held while disabled.
module rtc_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
    end
  end

  assign o_tick = i_enable && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/rtc_count_latch.sv
// Stopwatch count core: prescaled counter, capture on every i_latchcount edge,
// and MSB-first byte serialisation of each captured value.
module rtc_count_latch
  import rtc_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int PRESCALE    = 1
) (
  input  logic                   i_sclk,
  input  logic                   i_reset_n,
  input  logic                   i_countinit,
  input  logic                   i_countenb,
  input  logic                   i_latchcount,
  rtc_count_latch_if.master      rd,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic [COUNT_WIDTH-1:0] o_latched,
  output logic                   o_overflow
);
  localparam int RD_BYTES = rd_bytes(COUNT_WIDTH);
  localparam int IDX_W    = idx_width(RD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RD_BYTES - 1);

  logic                   w_tick;
  logic                   w_latch_evt;
  logic                   w_xfer;
  logic                   r_lc_q;
  rd_state_t              r_state;
  rd_state_t              w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_frame;
  logic [COUNT_WIDTH-1:0] w_frame_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   r_pending;
  logic                   w_pending_nxt;
  logic                   r_rd_valid;
  logic [7:0]             r_rd_data;
  logic                   r_rd_last;

  rtc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .i_clk    (i_sclk),
    .i_rst_n  (i_reset_n),
    .i_clear  (i_countinit),
    .i_enable (i_countenb),
    .o_tick   (w_tick)
  );

  assign w_latch_evt = (i_latchcount != r_lc_q);
  assign w_xfer      = r_rd_valid && rd.rd_ready;

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else if (i_countinit) begin
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else if (w_tick) begin
      o_count <= o_count + COUNT_WIDTH'(1);
      if (&o_count) o_overflow <= 1'b1;
    end
  end

  // Capture uses the pre-update count, so a coincident clear or tick is not seen.
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lc_q    <= 1'b0;
      o_latched <= '0;
    end else if (w_latch_evt) begin
      r_lc_q    <= i_latchcount;
      o_latched <= o_count;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_nxt   = r_frame;
    w_idx_nxt     = r_idx;
    w_pending_nxt = r_pending;
    case (r_state)
      RD_IDLE: begin
        if (w_latch_evt) begin
          w_state_nxt = RD_SEND;
          w_frame_nxt = o_count;
          w_idx_nxt   = LAST_IDX;
        end
      end
      RD_SEND: begin
        if (w_xfer && (r_idx == '0)) begin
          // A fresh event at the frame boundary supersedes any older pending value.
          if (w_latch_evt) begin
            w_frame_nxt   = o_count;
            w_idx_nxt     = LAST_IDX;
            w_pending_nxt = 1'b0;
          end else if (r_pending) begin
            w_frame_nxt   = o_latched;
            w_idx_nxt     = LAST_IDX;
            w_pending_nxt = 1'b0;
          end else begin
            w_state_nxt = RD_IDLE;
          end
        end else begin
          if (w_xfer) w_idx_nxt = r_idx - IDX_W'(1);
          if (w_latch_evt) w_pending_nxt = 1'b1;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= RD_IDLE;
      r_frame    <= '0;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_last  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_frame    <= w_frame_nxt;
      r_idx      <= w_idx_nxt;
      r_pending  <= w_pending_nxt;
      r_rd_valid <= (w_state_nxt == RD_SEND);
      r_rd_data  <= (w_state_nxt == RD_SEND) ? 8'(w_frame_nxt >> {w_idx_nxt, 3'b000}) : 8'h00;
      r_rd_last  <= (w_state_nxt == RD_SEND) && (w_idx_nxt == '0);
    end
  end

  assign rd.rd_valid = r_rd_valid;
  assign rd.rd_data  = r_rd_data;
  assign rd.rd_last  = r_rd_last;

endmodule
